// File: rtl/uart_pkg.sv
// Shared definitions for the multi-character UART transmitter: FSM state
// encoding, parity selector values and the default baud divisor.
package uart_pkg;

    // Transmitter FSM states. The encoding is visible on the debug state port.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4,
        ST_DONE  = 3'd5
    } uart_state_t;

    // Parity selector values for the PARITY parameter.
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // 115200 baud from a 100 MHz clock (100e6 / 115200 truncates to 868).
    localparam int CLK_HZ_100M           = 100_000_000;
    localparam int BAUD_115200           = 115_200;
    localparam int CLKS_115200_AT_100MHZ = CLK_HZ_100M / BAUD_115200;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and pulses o_tick
// during the last count of each bit. i_clear holds the count at zero.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign o_tick = i_enable & w_last;

    // Free-running bit counter that wraps at the end of every bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_multi.sv
// Burst UART transmitter: captures NUM_BYTES characters into a buffer and
// sends them back to back (start, data LSB first, optional parity, stop).
//
// Control handshake (all inputs are levels sampled on the rising edge):
//   CAPTURE     loads DATA only in IDLE or DONE; ignored while BUSY.
//   TRANSMIT    accepted only in IDLE; BUSY rises on the accepting edge.
//   ACKNOWLEDGE accepted only in DONE; SENT falls on the accepting edge.
module uart_tx_multi
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_115200_AT_100MHZ,
    parameter int DATA_BITS    = 8,
    parameter int NUM_BYTES    = 16,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic                              CLK,
    input  logic                              RST_N,
    input  logic [NUM_BYTES*DATA_BITS-1:0]    DATA,
    input  logic                              CAPTURE,
    input  logic                              TRANSMIT,
    input  logic                              ACKNOWLEDGE,
    output logic                              TX,
    output logic                              BUSY,
    output logic                              SENT,
    output logic [$clog2(NUM_BYTES+1)-1:0]    BYTE_IDX,
    output logic [2:0]                        DBG_STATE
);

    localparam int IDX_W = $clog2(NUM_BYTES + 1);
    localparam int BUF_W = NUM_BYTES * DATA_BITS;

    // Elaboration-time parameter legality.
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks
        $fatal(1, "uart_tx_multi: CLKS_PER_BIT must be 2..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $fatal(1, "uart_tx_multi: DATA_BITS must be 5..9");
    end
    if (NUM_BYTES < 1 || NUM_BYTES > 64) begin : g_bad_num_bytes
        $fatal(1, "uart_tx_multi: NUM_BYTES must be 1..64");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_parity
        $fatal(1, "uart_tx_multi: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $fatal(1, "uart_tx_multi: STOP_BITS must be 1 or 2");
    end

    logic [1:0]           r_rst_sync;
    logic                 w_rst_n;
    uart_state_t          r_state;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_sent;
    logic [IDX_W-1:0]     r_byte_idx;
    logic [3:0]           r_bit_cnt;
    logic [BUF_W-1:0]     r_buf;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 w_tick;
    logic                 w_timer_clear;
    logic [BUF_W-1:0]     w_buf_sel;
    logic [DATA_BITS-1:0] w_char;
    logic                 w_char_par;

    // Reset asserts immediately and releases two clock edges after RST_N rises.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_rst_n = r_rst_sync[1];

    // Character currently addressed by BYTE_IDX and its parity bit.
    assign w_buf_sel  = r_buf >> (32'(r_byte_idx) * DATA_BITS);
    assign w_char     = w_buf_sel[DATA_BITS-1:0];
    assign w_char_par = (^w_char) ^ (PARITY == PAR_ODD);

    // The timer only runs while a burst is active, so it sits at zero on entry.
    assign w_timer_clear = ~r_busy;

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .i_clk    (CLK),
        .i_rst_n  (w_rst_n),
        .i_clear  (w_timer_clear),
        .i_enable (r_busy),
        .o_tick   (w_tick)
    );

    // Transmit FSM with registered line, status and buffer.
    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= ST_IDLE;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_sent     <= 1'b0;
            r_byte_idx <= '0;
            r_bit_cnt  <= '0;
            r_buf      <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (CAPTURE) begin
                        r_buf <= DATA;
                    end
                    if (TRANSMIT) begin
                        r_state    <= ST_START;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_byte_idx <= '0;
                        r_bit_cnt  <= '0;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        r_state   <= ST_DATA;
                        r_tx      <= w_char[0];
                        r_shift   <= w_char >> 1;
                        r_par     <= w_char_par;
                        r_bit_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (r_bit_cnt == 4'(DATA_BITS - 1)) begin
                            r_bit_cnt <= '0;
                            if (PARITY != PAR_NONE) begin
                                r_state <= ST_PAR;
                                r_tx    <= r_par;
                            end else begin
                                r_state <= ST_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                        end
                    end
                end
                ST_PAR: begin
                    if (w_tick) begin
                        r_state   <= ST_STOP;
                        r_tx      <= 1'b1;
                        r_bit_cnt <= '0;
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        if (r_bit_cnt == 4'(STOP_BITS - 1)) begin
                            r_bit_cnt <= '0;
                            if (r_byte_idx == IDX_W'(NUM_BYTES - 1)) begin
                                r_state    <= ST_DONE;
                                r_tx       <= 1'b1;
                                r_busy     <= 1'b0;
                                r_sent     <= 1'b1;
                                r_byte_idx <= IDX_W'(NUM_BYTES);
                            end else begin
                                r_state    <= ST_START;
                                r_tx       <= 1'b0;
                                r_byte_idx <= r_byte_idx + IDX_W'(1);
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                end
                ST_DONE: begin
                    if (CAPTURE) begin
                        r_buf <= DATA;
                    end
                    if (ACKNOWLEDGE) begin
                        r_state    <= ST_IDLE;
                        r_sent     <= 1'b0;
                        r_byte_idx <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_sent  <= 1'b0;
                end
            endcase
        end
    end

    assign TX        = r_tx;
    assign BUSY      = r_busy;
    assign SENT      = r_sent;
    assign BYTE_IDX  = r_byte_idx;
    assign DBG_STATE = r_state;

endmodule

// File: tb/tb_uart_tx_multi.sv
// Bench for uart_tx_multi: a 6-character even-parity instance driven from a
// vector table plus hand-written DONE/reset sequences, and a 2-character
// 7-bit odd-parity two-stop-bit instance checked against fixed bit streams.
module tb_uart_tx_multi;

  localparam int CPB_A = 4;
  localparam int CPB_B = 3;

  logic        clk;
  logic        rst_n;

  logic [47:0] data_a;
  logic        cap_a, go_a, ack_a;
  logic        tx_a, busy_a, sent_a;
  logic [2:0]  idx_a, st_a;

  logic [13:0] data_b;
  logic        cap_b, go_b, ack_b;
  logic        tx_b, busy_b, sent_b;
  logic [1:0]  idx_b;
  logic [2:0]  st_b;

  int n_checks = 0;
  int n_err    = 0;

  uart_tx_multi #(
    .CLKS_PER_BIT (CPB_A), .DATA_BITS (8), .NUM_BYTES (6), .PARITY (1), .STOP_BITS (1)
  ) dut_a (
    .CLK (clk), .RST_N (rst_n), .DATA (data_a), .CAPTURE (cap_a), .TRANSMIT (go_a),
    .ACKNOWLEDGE (ack_a), .TX (tx_a), .BUSY (busy_a), .SENT (sent_a),
    .BYTE_IDX (idx_a), .DBG_STATE (st_a)
  );

  uart_tx_multi #(
    .CLKS_PER_BIT (CPB_B), .DATA_BITS (7), .NUM_BYTES (2), .PARITY (2), .STOP_BITS (2)
  ) dut_b (
    .CLK (clk), .RST_N (rst_n), .DATA (data_b), .CAPTURE (cap_b), .TRANSMIT (go_b),
    .ACKNOWLEDGE (ack_b), .TX (tx_b), .BUSY (busy_b), .SENT (sent_b),
    .BYTE_IDX (idx_b), .DBG_STATE (st_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [47:0] data;      // payload expected on the line (and driven when captured)
    logic [5:0]  par;       // hand-computed even parity, bit k for character k
    int          mode;      // 0: transmit only, 1: capture then transmit, 2: both same cycle
    bit          mid_en;    // pulse CAPTURE with mid_data during character 3
    logic [47:0] mid_data;
  } vec_t;

  vec_t tbl[5];

  // ---------------- driver tasks ----------------
  // Called at a negedge in IDLE; leaves TRANSMIT high for the next edge.
  task automatic start_burst_a(input int mode, input logic [47:0] d);
    if (mode == 1) begin
      data_a = d;
      cap_a  = 1'b1;
      @(negedge clk);
      cap_a  = 1'b0;
      go_a   = 1'b1;
    end else if (mode == 2) begin
      data_a = d;
      cap_a  = 1'b1;
      go_a   = 1'b1;
    end else begin
      go_a   = 1'b1;
    end
  endtask

  // Walks every cycle of the 6-character burst and then checks DONE.
  task automatic check_burst_a(input logic [47:0] exp_d, input logic [5:0] exp_p,
                               input bit mid_en, input logic [47:0] mid_d, input string tag);
    logic e;
    int   n_bad;
    for (int k = 0; k < 6; k++) begin
      for (int b = 0; b < 11; b++) begin
        if (b == 0)       e = 1'b0;
        else if (b <= 8)  e = exp_d[k*8 + b - 1];
        else if (b == 9)  e = exp_p[k];
        else              e = 1'b1;
        n_bad = 0;
        for (int c = 0; c < CPB_A; c++) begin
          @(negedge clk);
          if (k == 0 && b == 0 && c == 0) begin
            go_a  = 1'b0;
            cap_a = 1'b0;
          end
          if (mid_en && k == 3 && b == 2 && c == 0) begin
            data_a = mid_d;
            cap_a  = 1'b1;
          end else if (mid_en && k == 3 && b == 2 && c == 1) begin
            cap_a  = 1'b0;
          end
          if (tx_a !== e) n_bad++;
          if (b == 0 && c == 0) begin
            check($sformatf("%s_idx_k%0d", tag, k), 64'(idx_a), 64'(k));
            check($sformatf("%s_busy_k%0d", tag, k), 64'(busy_a), 64'd1);
          end
        end
        check($sformatf("%s_tx_k%0d_b%0d_badcycles", tag, k, b), 64'(n_bad), 64'd0);
      end
    end
    @(negedge clk);
    check({tag, "_done_sent"}, 64'(sent_a), 64'd1);
    check({tag, "_done_busy"}, 64'(busy_a), 64'd0);
    check({tag, "_done_tx"},   64'(tx_a),   64'd1);
    check({tag, "_done_idx"},  64'(idx_a),  64'd6);
    check({tag, "_done_state"}, 64'(st_a),  64'd5);
  endtask

  // Called at a negedge in DONE; returns at a negedge in IDLE.
  task automatic ack_a_task(input string tag);
    ack_a = 1'b1;
    @(negedge clk);
    ack_a = 1'b0;
    check({tag, "_ack_sent"}, 64'(sent_a), 64'd0);
    check({tag, "_ack_idx"},  64'(idx_a),  64'd0);
    check({tag, "_ack_tx"},   64'(tx_a),   64'd1);
  endtask

  task automatic run_b(input logic [13:0] d, input logic [21:0] exp_bits, input string tag);
    int n_bad;
    data_b = d;
    cap_b  = 1'b1;
    go_b   = 1'b1;
    for (int i = 0; i < 22; i++) begin
      n_bad = 0;
      for (int c = 0; c < CPB_B; c++) begin
        @(negedge clk);
        cap_b = 1'b0;
        go_b  = 1'b0;
        if (tx_b !== exp_bits[i]) n_bad++;
      end
      check($sformatf("%s_bit%0d_badcycles", tag, i), 64'(n_bad), 64'd0);
    end
    @(negedge clk);
    check({tag, "_sent"}, 64'(sent_b), 64'd1);
    check({tag, "_idx"},  64'(idx_b),  64'd2);
    ack_b = 1'b1;
    @(negedge clk);
    ack_b = 1'b0;
    check({tag, "_ack_sent"}, 64'(sent_b), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n_bad_tx;
    int n_bad_sent;

    tbl[0] = '{data: 48'h000000000000, par: 6'b000000, mode: 1, mid_en: 1'b0, mid_data: 48'h0};
    tbl[1] = '{data: 48'h050403020100, par: 6'b010110, mode: 2, mid_en: 1'b1, mid_data: 48'h13FE7F01AA55};
    tbl[2] = '{data: 48'h050403020100, par: 6'b010110, mode: 0, mid_en: 1'b0, mid_data: 48'h0};
    tbl[3] = '{data: 48'h13FE7F01AA55, par: 6'b111100, mode: 1, mid_en: 1'b0, mid_data: 48'h0};
    tbl[4] = '{data: 48'hFCF8F0E0C080, par: 6'b010101, mode: 2, mid_en: 1'b0, mid_data: 48'h0};

    rst_n  = 1'b0;
    data_a = '0; cap_a = 1'b0; go_a = 1'b0; ack_a = 1'b0;
    data_b = '0; cap_b = 1'b0; go_b = 1'b0; ack_b = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_tx_a",    64'(tx_a),   64'd1);
    check("rst_busy_a",  64'(busy_a), 64'd0);
    check("rst_sent_a",  64'(sent_a), 64'd0);
    check("rst_idx_a",   64'(idx_a),  64'd0);
    check("rst_state_a", 64'(st_a),   64'd0);
    check("rst_tx_b",    64'(tx_b),   64'd1);

    // TRANSMIT held across reset release must not start a frame on the first edge.
    go_a  = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_edge1_tx_a", 64'(tx_a), 64'd1);
    go_a = 1'b0;
    repeat (3) @(negedge clk);
    check("rel_idle_tx_a", 64'(tx_a), 64'd1);

    // Table-driven bursts.
    for (int v = 0; v < 5; v++) begin
      start_burst_a(tbl[v].mode, tbl[v].data);
      check_burst_a(tbl[v].data, tbl[v].par, tbl[v].mid_en, tbl[v].mid_data,
                    $sformatf("vec%0d", v));
      ack_a_task($sformatf("vec%0d", v));
    end

    // DONE behaviour: TRANSMIT ignored, ACKNOWLEDGE clears SENT, next burst starts promptly.
    start_burst_a(1, 48'h050403020100);
    check_burst_a(48'h050403020100, 6'b010110, 1'b0, 48'h0, "done_seq");
    go_a = 1'b1;
    n_bad_tx   = 0;
    n_bad_sent = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_a !== 1'b1)   n_bad_tx++;
      if (sent_a !== 1'b1) n_bad_sent++;
    end
    check("done_hold_tx_low_cycles",  64'(n_bad_tx),   64'd0);
    check("done_hold_sent_low_cycles", 64'(n_bad_sent), 64'd0);
    go_a  = 1'b0;
    ack_a = 1'b1;
    @(negedge clk);
    ack_a = 1'b0;
    check("done_ack_sent", 64'(sent_a), 64'd0);
    go_a = 1'b1;
    @(negedge clk);
    go_a = 1'b0;
    check("restart_tx",   64'(tx_a),   64'd0);
    check("restart_busy", 64'(busy_a), 64'd1);

    // Move to mid data bit 4 of character 5 (offset 5*44 + 5*4 + 2) and reset.
    repeat (242) @(negedge clk);
    check("mid_b5_tx",   64'(tx_a),   64'd0);
    check("mid_b5_idx",  64'(idx_a),  64'd5);
    check("mid_b5_busy", 64'(busy_a), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_tx",   64'(tx_a),   64'd1);
    check("abort_busy", 64'(busy_a), 64'd0);
    check("abort_sent", 64'(sent_a), 64'd0);
    check("abort_idx",  64'(idx_a),  64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_abort_tx", 64'(tx_a), 64'd1);

    // Buffer was cleared by reset: a transmit without capture sends zeros from character 0.
    start_burst_a(0, 48'h0);
    check_burst_a(48'h0, 6'b000000, 1'b0, 48'h0, "post_rst");
    ack_a_task("post_rst");

    // Second configuration: 7 data bits, odd parity, two stop bits, two characters.
    run_b(14'h3FFF,
          {2'b11, 1'b0, 7'h7F, 1'b0, 2'b11, 1'b0, 7'h7F, 1'b0}, "b_ones");
    run_b(14'h0080,
          {2'b11, 1'b0, 7'b0000001, 1'b0, 2'b11, 1'b1, 7'b0000000, 1'b0}, "b_mixed");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
